// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO between MEM stage and single-port data RAM.
// MEM side: mem_write_i/mem_read_i/addr_i/wdata_i/funct3_i/be_i -> rdata_o/stall_o/empty_o.
// RAM side: ram_ready_i/ram_rdata_i in, ram_we_o/ram_addr_o/ram_be_o/ram_wdata_o out.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        funct3_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              empty_o,
  input  logic              ram_ready_i,
  output logic              ram_we_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] validQ;
  logic [WW-1:0]    addrQ [DEPTH];
  logic [31:0]      dataQ [DEPTH];
  logic [3:0]       beQ   [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic          loadReq;
  logic          storeReq;
  logic          full;
  logic          drain;
  logic          accept;
  logic [WW-1:0] wordAddr;
  logic [31:0]   alignData;

  assign wordAddr = addr_i[ADDR_W-1:2];
  // a load always owns the RAM port, even if a store is
  // (illegally) raised alongside it
  assign loadReq  = mem_read_i;
  assign storeReq = mem_write_i & ~mem_read_i;
  assign full     = count == FULL;
  assign drain    = ~loadReq & ram_ready_i & (count != '0);
  // a full buffer still takes a store when the head leaves
  assign accept   = storeReq & (~full | drain);
  assign stall_o  = (storeReq & full & ~drain)
                  | (loadReq & ~ram_ready_i);
  assign empty_o  = count == '0;

  always_comb begin
    alignData = wdata_i;
    unique case (1'b1)
      funct3_i[1:0] == 2'b00: alignData = {4{wdata_i[7:0]}};
      funct3_i[1:0] == 2'b01: alignData = {2{wdata_i[15:0]}};
      default:                alignData = wdata_i;
    endcase
  end

  always_comb begin
    ram_we_o    = drain;
    ram_addr_o  = loadReq ? wordAddr : addrQ[head];
    ram_be_o    = beQ[head];
    ram_wdata_o = dataQ[head];
  end

  // walk oldest to youngest so the youngest byte lands last
  always_comb begin
    logic [PW-1:0] idx;
    idx     = head;
    rdata_o = ram_rdata_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (validQ[idx] && addrQ[idx] == wordAddr) begin
        for (int b = 0; b < 4; b++) begin
          if (beQ[idx][b]) begin
            rdata_o[8*b +: 8] = dataQ[idx][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validQ <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (drain) begin
        validQ[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      // when full, tail==head: the new entry reuses the drained slot
      if (accept) begin
        validQ[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      unique case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addrQ[tail] <= wordAddr;
      dataQ[tail] <= alignData;
      beQ[tail]   <= be_i;
    end
  end

endmodule
